sopc_run_ctrl: RTL and testbench

- Synthesizable run controller placed beside the SOPC core in simulation and FPGA bring-up builds.
- Sequences the core reset and counts run cycles against a parametrised budget.
- Detects program end (halt), timeout and hang (PC stuck), then latches a final status for the bench or a debug LED/UART.
- Replaces hard-coded reset delays and cycle limits in benches with a single parametrised, reusable block.

---
 rtl/sopc_run_ctrl_pkg.sv | 8 +
 rtl/sopc_run_ctrl_if.sv | 24 ++
 rtl/sopc_run_ctrl_stall_det.sv | 28 ++
 rtl/sopc_run_ctrl.sv | 73 +++++++
 tb/tb_sopc_run_ctrl.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/sopc_run_ctrl_pkg.sv
// sopc_pkg: status codes and FSM state encoding shared by the run controller
package sopc_pkg;
  localparam logic [1:0] ST_RUN     = 2'b00;
  localparam logic [1:0] ST_HALT    = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;
  localparam logic [1:0] ST_HANG    = 2'b11;
  typedef enum logic [1:0] {S_HOLD = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;
endpackage

// File: rtl/sopc_run_ctrl_if.sv
// sopc_run_ctrl_if: core-side signals of the run controller (perf ports under SOPC_RUN_PERF_EN)
interface sopc_run_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 23
) ();
  logic              halt_i;
  logic [ADDR_W-1:0] pc_i;
  logic              core_rst_o;
  logic              done_o;
  logic [1:0]        status_o;
  logic [CNT_W-1:0]  cycle_cnt_o;
`ifdef SOPC_RUN_PERF_EN
  logic              inst_valid_i;
  logic [CNT_W-1:0]  retired_o;
  logic              cpi_flag_o;
  modport slave  (input halt_i, pc_i, inst_valid_i,
                  output core_rst_o, done_o, status_o, cycle_cnt_o, retired_o, cpi_flag_o);
  modport master (output halt_i, pc_i, inst_valid_i,
                  input core_rst_o, done_o, status_o, cycle_cnt_o, retired_o, cpi_flag_o);
`else
  modport slave  (input halt_i, pc_i, output core_rst_o, done_o, status_o, cycle_cnt_o);
  modport master (output halt_i, pc_i, input core_rst_o, done_o, status_o, cycle_cnt_o);
`endif
endinterface

// File: rtl/sopc_run_ctrl_stall_det.sv
// sopc_stall_det: last-PC register and saturating count of consecutive unchanged PC samples
module sopc_stall_det #(
  parameter int ADDR_W      = 32,
  parameter int STALL_LIMIT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_en,
  input  logic [ADDR_W-1:0] i_pc,
  output logic              stall_hit
);
  localparam int SW = $clog2(STALL_LIMIT + 1);
  logic [ADDR_W-1:0] r_last_pc;
  logic [SW-1:0]     r_stall;
  logic              w_same;
  assign w_same    = i_pc == r_last_pc;
  assign stall_hit = w_same && r_stall == SW'(STALL_LIMIT - 1);
  // track the previous PC and how long it has stayed put, only while the core runs
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_last_pc <= '0;
      r_stall   <= '0;
    end else if (i_en) begin
      r_last_pc <= i_pc;
      r_stall   <= !w_same ? '0 : r_stall == SW'(STALL_LIMIT) ? r_stall : r_stall + 1'b1;
    end
  end
endmodule

// File: rtl/sopc_run_ctrl.sv
// sopc_run_ctrl: core reset sequencing, run budget and halt/timeout/hang status (SOPC_RUN_PERF_EN adds retire stats)
module sopc_run_ctrl
  import sopc_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int CNT_W       = 23,
  parameter int RST_CYCLES  = 10,
  parameter int MAX_CYCLES  = 80,
  parameter int STALL_LIMIT = 16
) (
  input  logic            clk,
  input  logic            reset,
  sopc_run_ctrl_if.slave  bus
);
  localparam int HW = $clog2(RST_CYCLES + 1);
  if (longint'(MAX_CYCLES) >= (longint'(1) << CNT_W)) begin : g_max_chk
    $error("MAX_CYCLES must be below 2**CNT_W");
  end
  if (RST_CYCLES < 1 || STALL_LIMIT < 2) begin : g_par_chk
    $error("RST_CYCLES must be >= 1 and STALL_LIMIT >= 2");
  end
  state_t           r_state, w_next;
  logic [HW-1:0]    r_hold;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_status, w_code;
  logic             w_timeout, w_exit, w_stall_hit;
  sopc_stall_det #(.ADDR_W(ADDR_W), .STALL_LIMIT(STALL_LIMIT)) u_stall (
    .clk       (clk),
    .reset     (reset),
    .i_en      (r_state == S_RUN),
    .i_pc      (bus.pc_i),
    .stall_hit (w_stall_hit)
  );
  // exit detection with halt > timeout > hang priority, and state advance
  always_comb begin
    w_timeout = r_cnt == CNT_W'(MAX_CYCLES - 1);
    w_exit    = r_state == S_RUN && (bus.halt_i || w_timeout || w_stall_hit);
    w_code    = bus.halt_i ? ST_HALT : w_timeout ? ST_TIMEOUT : ST_HANG;
    w_next    = w_exit ? S_DONE
              : (r_state == S_HOLD && r_hold == HW'(RST_CYCLES - 1)) ? S_RUN : r_state;
  end
  // state register; DONE is left only through reset
  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_HOLD;
    else        r_state <= w_next;
  end
  // hold/run counters and the latched final status
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_hold   <= '0;
      r_cnt    <= '0;
      r_status <= ST_RUN;
    end else begin
      if (r_state == S_HOLD) r_hold <= r_hold + 1'b1;
      if (r_state == S_RUN) r_cnt <= r_cnt + 1'b1;
      if (w_exit) r_status <= w_code;
    end
  end
  assign bus.core_rst_o  = r_state == S_HOLD;
  assign bus.done_o      = r_state == S_DONE;
  assign bus.status_o    = r_status;
  assign bus.cycle_cnt_o = r_cnt;
`ifdef SOPC_RUN_PERF_EN
  logic [CNT_W-1:0] r_retired;
  // count RUN cycles in which the core retires an instruction
  always_ff @(posedge clk) begin
    if (!reset) r_retired <= '0;
    else if (r_state == S_RUN && bus.inst_valid_i) r_retired <= r_retired + 1'b1;
  end
  assign bus.retired_o  = r_retired;
  assign bus.cpi_flag_o = r_state == S_DONE && ({r_retired, 1'b0} < {1'b0, r_cnt});
`endif
endmodule

// File: tb/tb_sopc_run_ctrl.sv
// tb_sopc_run_ctrl: directed table, mid-run reset and randomized runs against a run-outcome model
module tb_sopc_run_ctrl;
  import sopc_pkg::*;
  localparam int ADDR_W = 32, CNT_W = 23, RST = 10, MAX = 80, SL = 16, NT = 9;
  typedef struct {
    int          halt_at;
    int          eq_from;
    logic [31:0] hold_pc;
    logic [31:0] pc_start;
    int          vper;
    logic [1:0]  exp_code;
    int          exp_cnt;
    int          exp_ret;
    bit          exp_cpi;
  } vec_t;
  logic clk = 1'b0;
  logic reset;
  int n_chk = 0, n_pass = 0;
  bit          st_halt [MAX];
  logic [31:0] st_pc   [MAX];
`ifdef SOPC_RUN_PERF_EN
  bit          st_valid[MAX];
`endif
  vec_t tbl[NT];
  always #5 clk = ~clk;
  sopc_run_ctrl_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();
  sopc_run_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .RST_CYCLES(RST), .MAX_CYCLES(MAX),
                  .STALL_LIMIT(SL)) dut (.clk(clk), .reset(reset), .bus(bus));

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  // outcome of a run: first RUN cycle where halt, budget end, or a long enough equal-PC streak occurs
  task automatic model(output int ke, output logic [1:0] code);
    int streak = 0;
    ke = MAX - 1;
    code = ST_TIMEOUT;
    for (int k = 0; k < MAX; k++) begin
      logic [31:0] prev;
      prev = (k == 0) ? 32'h0 : st_pc[k-1];
      streak = (st_pc[k] == prev) ? streak + 1 : 0;
      if (st_halt[k]) begin ke = k; code = ST_HALT; return; end
      if (k == MAX - 1) begin ke = k; code = ST_TIMEOUT; return; end
      if (streak >= SL) begin ke = k; code = ST_HANG; return; end
    end
  endtask

  task automatic load_vec(input vec_t v);
    for (int k = 0; k < MAX; k++) begin
      st_halt[k] = (k == v.halt_at);
      st_pc[k]   = (v.eq_from >= 0 && k >= v.eq_from - 1) ? v.hold_pc : v.pc_start + 32'(4 * k);
`ifdef SOPC_RUN_PERF_EN
      st_valid[k] = (k % v.vper) == 0;
`endif
    end
  endtask

  task automatic gen_random();
    int stick, hr;
    stick = int'($urandom_range(0, 100));
    hr = int'($urandom_range(30, 600));
    for (int k = 0; k < MAX; k++) begin
      logic [31:0] prev;
      prev = (k == 0) ? 32'h0 : st_pc[k-1];
      st_halt[k] = $urandom_range(0, hr) == 0;
      st_pc[k] = (int'($urandom_range(0, 99)) < stick) ? prev
               : ($urandom_range(0, 7) == 0) ? 32'h0 : prev + 32'h4;
`ifdef SOPC_RUN_PERF_EN
      st_valid[k] = 1'($urandom);
`endif
    end
  endtask

  // RUN-cycle stimulus while the run is live, random noise elsewhere
  task automatic drive(input int k, input int ke);
    if (k >= 0 && k <= ke) begin
      bus.halt_i = st_halt[k];
      bus.pc_i   = st_pc[k];
`ifdef SOPC_RUN_PERF_EN
      bus.inst_valid_i = st_valid[k];
`endif
    end else begin
      bus.halt_i = 1'($urandom);
      bus.pc_i   = $urandom;
`ifdef SOPC_RUN_PERF_EN
      bus.inst_valid_i = 1'($urandom);
`endif
    end
  endtask

  // observation i is taken i clock edges after reset release
  task automatic observe(input string nm, input int i, input int ke, input logic [1:0] code);
    int k;
    bit fin;
    k = i - RST;
    fin = k > ke;
    check({nm, "_core_rst"}, 32'(bus.core_rst_o), 32'(i < RST));
    check({nm, "_done"}, 32'(bus.done_o), 32'(fin));
    check({nm, "_status"}, 32'(bus.status_o), fin ? 32'(code) : 32'(ST_RUN));
    check({nm, "_cycle_cnt"}, 32'(bus.cycle_cnt_o), fin ? 32'(ke + 1) : (k < 0 ? 32'd0 : 32'(k)));
`ifdef SOPC_RUN_PERF_EN
    begin
      int ret, n;
      ret = 0;
      n = fin ? ke + 1 : k;
      for (int j = 0; j < n; j++) ret += int'(st_valid[j]);
      check({nm, "_retired"}, 32'(bus.retired_o), 32'(ret));
      check({nm, "_cpi_flag"}, 32'(bus.cpi_flag_o), 32'(fin && 2 * ret < ke + 1));
    end
`endif
  endtask

  task automatic run_case(input string nm, input int rst_len, input int abort_at);
    int ke;
    logic [1:0] code;
    model(ke, code);
    for (int j = 0; j < rst_len; j++) begin
      reset = 1'b0;
      drive(-1, ke);
      @(negedge clk);
    end
    for (int i = 0; i < RST + ke + 6; i++) begin
      observe(nm, i, ke, code);
      if (abort_at >= 0 && i - RST == abort_at) begin
        reset = 1'b0;
        drive(-1, ke);
        @(negedge clk);
        return;
      end
      reset = 1'b1;
      drive(i - RST, ke);
      @(negedge clk);
    end
  endtask

  initial begin
    tbl[0] = '{-1, -1, 32'h0,  32'h0,    2, ST_TIMEOUT, 80, 40, 1'b0};
    tbl[1] = '{-1, -1, 32'h0,  32'h1000, 4, ST_TIMEOUT, 80, 20, 1'b1};
    tbl[2] = '{25, -1, 32'h0,  32'h0,    1, ST_HALT,    26, 26, 1'b0};
    tbl[3] = '{-1, 30, 32'h40, 32'h100,  3, ST_HANG,    46, 16, 1'b1};
    tbl[4] = '{79, -1, 32'h0,  32'h0,    2, ST_HALT,    80, 40, 1'b0};
    tbl[5] = '{-1,  0, 32'h0,  32'h0,    1, ST_HANG,    16, 16, 1'b0};
    tbl[6] = '{15,  0, 32'h0,  32'h0,    1, ST_HALT,    16, 16, 1'b0};
    tbl[7] = '{-1, 64, 32'h40, 32'h100,  2, ST_TIMEOUT, 80, 40, 1'b0};
    tbl[8] = '{-1, 63, 32'h40, 32'h100,  2, ST_HANG,    79, 40, 1'b0};
    reset = 1'b0;
    bus.halt_i = 1'b0;
    bus.pc_i = '0;
`ifdef SOPC_RUN_PERF_EN
    bus.inst_valid_i = 1'b0;
`endif
    @(negedge clk);
    for (int t = 0; t < NT; t++) begin
      load_vec(tbl[t]);
      run_case($sformatf("tbl%0d", t), 3, -1);
      check($sformatf("tbl%0d_final_status", t), 32'(bus.status_o), 32'(tbl[t].exp_code));
      check($sformatf("tbl%0d_final_cnt", t), 32'(bus.cycle_cnt_o), 32'(tbl[t].exp_cnt));
`ifdef SOPC_RUN_PERF_EN
      check($sformatf("tbl%0d_final_retired", t), 32'(bus.retired_o), 32'(tbl[t].exp_ret));
      check($sformatf("tbl%0d_final_cpi", t), 32'(bus.cpi_flag_o), 32'(tbl[t].exp_cpi));
`endif
    end
    load_vec(tbl[0]);
    run_case("abort", 3, 40);
    run_case("fresh", 0, -1);
    check("fresh_final_status", 32'(bus.status_o), 32'(ST_TIMEOUT));
    check("fresh_final_cnt", 32'(bus.cycle_cnt_o), 32'd80);
    for (int r = 0; r < 24; r++) begin
      gen_random();
      run_case($sformatf("rnd%0d", r), int'($urandom_range(1, 3)), -1);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
